iob_eth_tx_serializer: RTL



---
 rtl/iob_eth_tx_serializer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/iob_eth_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : iob_eth_tx_serializer
// Description : Ethernet MAC transmit nibble serializer. Takes a byte stream
//               over valid/ready, prepends preamble + SFD, sends each byte
//               low nibble first on MII and enforces the inter-frame gap.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_eth_tx_serializer #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_NIBBLES    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [3:0] mii_txd,
  output logic       mii_tx_en,
  output logic       busy,
  output logic       underrun
);

  // Index of the SFD (0xD) nibble inside the preamble phase.
  localparam int PRE_LAST = 2 * PREAMBLE_BYTES + 1;
  // One shared counter serves both the preamble and the gap phases.
  localparam int CNT_MAX  = (PRE_LAST > IFG_NIBBLES - 1) ? PRE_LAST : IFG_NIBBLES - 1;
  localparam int CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PRE_LAST_C = CNT_W'(PRE_LAST);
  localparam logic [CNT_W-1:0] IFG_LOAD_C = CNT_W'(IFG_NIBBLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE     = 3'd1,
    DATA_LO = 3'd2,
    DATA_HI = 3'd3,
    IFG     = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       data_q, data_next;
  logic             last_q, last_next;
  logic [3:0]       txd_next;
  logic             en_next;
  logic             busy_next;
  logic             underrun_next;
  logic             xfer;

  // Ready is a pure decode of registered state: the SFD cycle, or the high
  // nibble of a byte that was not flagged as the last one.
  assign tx_ready = ((state == PRE) && (cnt == PRE_LAST_C)) ||
                    ((state == DATA_HI) && !last_q);
  assign xfer     = tx_valid && tx_ready;

  // Next-state, counter, byte latch and next-output decode.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    data_next     = data_q;
    last_next     = last_q;
    underrun_next = 1'b0;

    case (state)
      IDLE: begin
        if (tx_valid) begin
          state_next = PRE;
          cnt_next   = '0;
        end
      end
      PRE: begin
        if (cnt == PRE_LAST_C) begin
          if (xfer) begin
            state_next = DATA_LO;
            data_next  = tx_data;
            last_next  = tx_last;
          end else begin
            // No first byte at the SFD: abandon the frame.
            state_next    = IFG;
            cnt_next      = IFG_LOAD_C;
            underrun_next = 1'b1;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DATA_LO: begin
        state_next = DATA_HI;
      end
      DATA_HI: begin
        if (last_q) begin
          state_next = IFG;
          cnt_next   = IFG_LOAD_C;
        end else if (xfer) begin
          state_next = DATA_LO;
          data_next  = tx_data;
          last_next  = tx_last;
        end else begin
          // Mid-frame starvation: truncate after this nibble.
          state_next    = IFG;
          cnt_next      = IFG_LOAD_C;
          underrun_next = 1'b1;
        end
      end
      IFG: begin
        if (cnt == '0) begin
          if (tx_valid) begin
            state_next = PRE;
            cnt_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Outputs are decoded from the next state so that the registered pins
    // line up with the state they describe.
    en_next  = 1'b0;
    txd_next = 4'h0;
    case (state_next)
      PRE: begin
        en_next  = 1'b1;
        txd_next = (cnt_next == PRE_LAST_C) ? 4'hD : 4'h5;
      end
      DATA_LO: begin
        en_next  = 1'b1;
        txd_next = data_next[3:0];
      end
      DATA_HI: begin
        en_next  = 1'b1;
        txd_next = data_next[7:4];
      end
      default: begin
        en_next  = 1'b0;
        txd_next = 4'h0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // State, counter, byte latch and registered MII outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= 8'h00;
      last_q    <= 1'b0;
      mii_txd   <= 4'h0;
      mii_tx_en <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      data_q    <= data_next;
      last_q    <= last_next;
      mii_txd   <= txd_next;
      mii_tx_en <= en_next;
      busy      <= busy_next;
      underrun  <= underrun_next;
    end
  end

endmodule
`default_nettype wire
